bp_btb_param: RTL and testbench
===============================

# bp_btb_param

Parametrised branch target buffer and direction predictor for the five-stage RISC-V pipeline. Replaces the fixed four-entry predictor with a configurable direct-mapped table, saturating direction counters, execute-stage mispredict and redirect generation, and performance counters. The block sits beside the fetch PC register: it predicts combinationally on PCF and is trained from the execute stage.

## Interface
Parameters:
- ENTRIES, 16, table depth; power of two, 2..256; index = pc[IDX_W+1:2], IDX_W = log2(ENTRIES).
- CNT_W, 2, direction counter width (1..3); MSB = predict taken.
- PERF_W, 32, width of each performance counter.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high; clears the table and the counters.
- i_pcF  in  32  fetch PC.
- o_predtakenF  out  1  prediction: taken.
- o_predtargetF  out  32  predicted target; 0 when o_predtakenF=0.
- i_validE  in  1  execute-stage instruction valid (not flushed or bubbled).
- i_branchE  in  1  conditional branch in E.
- i_jumpE  in  1  jal/jalr in E.
- i_takenE  in  1  resolved branch outcome (ignored for jumps; jumps count as taken).
- i_pcE  in  32  PC of the E instruction.
- i_targetE  in  32  resolved target.
- i_pcplus4E  in  32  fall-through PC.
- i_predtakenE, i_predtargetE  in  1/32  prediction carried down the pipeline from F.
- o_mispredictE  out  1  redirect required.
- o_redirectE  out  32  correct next PC.
- o_branch_cnt, o_miss_cnt  out  PERF_W  resolved control-flow count and mispredict count.

## Operation
- Entry fields: valid, tag = pc[31:IDX_W+2], target[31:2], jump flag, counter[CNT_W-1:0].
- Lookup (combinational): hit = valid & tag match. o_predtakenF = hit & (jump flag | counter MSB). o_predtargetF = {target,2'b00} when o_predtakenF=1, else 0.
- Resolve (E, combinational): cf = i_validE & (i_branchE | i_jumpE); actual = i_jumpE | i_takenE.
- o_mispredictE = cf & ((actual != i_predtakenE) | (actual & i_predtakenE & i_predtargetE != i_targetE)).
- o_redirectE = actual ? i_targetE : i_pcplus4E, driven whenever cf=1, else 0.
- Update (posedge, only when cf=1):
  - hit on i_pcE, branch: counter +1 if taken, −1 if not, saturating at 2^CNT_W−1 and 0; target rewritten when taken.
  - hit, jump: jump flag=1, counter saturated high, target rewritten.
  - miss, actual taken: allocate; overwrite the slot (valid=1, new tag, target, jump flag=i_jumpE, counter = 2^(CNT_W−1), weakly taken; saturated high for jumps).
  - miss, not taken: no change.
- Perf: o_branch_cnt +1 per cf; o_miss_cnt +1 per o_mispredictE; both saturate at all-ones and never wrap.

## Timing
- Lookup and resolve have zero latency; table updates are visible on the cycle after the edge.
- Same-cycle lookup and update of the same index: the lookup returns the pre-update contents (no bypass).
- The table is insensitive to fetch stall; o_predtakenF follows i_pcF continuously.
- Reset, including mid-operation: all valid bits 0, counters 2^(CNT_W−1)−1 (weakly not taken), jump flags 0, perf counters 0. All outputs read 0 while reset is high and on the first cycle after it.
- A cycle with i_validE=0 performs no update, no count, and drives o_mispredictE=0.

## Configuration
- BP_DIR_COUNTER_EN defined: direction counters as described, CNT_W honoured.
- Undefined: CNT_W is forced to 1 (last-outcome predictor). The allocate value and the hit-update value become the actual outcome, and the jump flag is still kept.

## Test plan
- Reset, then i_pcF=0x100 → o_predtakenF=0, o_predtargetF=0. Counters read 0.
- Taken branch at i_pcE=0x100, target 0x40, predtaken=0 → o_mispredictE=1, redirect 0x40. Next cycle i_pcF=0x100 → predtaken=1, target 0x40. o_branch_cnt=1, o_miss_cnt=1.
- Same branch not taken twice with CNT_W=2 (10→01→00) → prediction goes to 0 after the first not-taken. A third not-taken keeps the counter at 00.
- Aliasing, ENTRIES=16: taken branch at 0x100, then taken branch at 0x140 (same index) → lookup at 0x100 misses and lookup at 0x140 hits.
- jal at 0x200 predicted to 0x300, actual 0x304 → mispredict=1, redirect 0x304, entry retargeted. A same-cycle lookup of 0x200 still returns 0x300.
- Reset asserted asynchronously mid-stream after several updates → every lookup misses and both counters are 0. With PERF_W=4, 20 resolved branches → o_branch_cnt holds at 15.

Source files
------------

// File: rtl/bp_btb_param_if.sv
// bp_btb_param_if
//   Fetch-side lookup and execute-side training bundle for the branch target
//   buffer. The pipeline side uses the master modport; the predictor uses
//   the slave modport.
//   Fetch    : i_pcF -> o_predtakenF, o_predtargetF
//   Execute  : i_validE, i_branchE, i_jumpE, i_takenE, i_pcE, i_targetE,
//              i_pcplus4E, i_predtakenE, i_predtargetE
//              -> o_mispredictE, o_redirectE
//   Perf     : o_branch_cnt, o_miss_cnt (PERF_W bits each)
interface bp_btb_param_if #(
  parameter int PERF_W = 32
);
  logic [31:0]       i_pcF;
  logic              o_predtakenF;
  logic [31:0]       o_predtargetF;
  logic              i_validE;
  logic              i_branchE;
  logic              i_jumpE;
  logic              i_takenE;
  logic [31:0]       i_pcE;
  logic [31:0]       i_targetE;
  logic [31:0]       i_pcplus4E;
  logic              i_predtakenE;
  logic [31:0]       i_predtargetE;
  logic              o_mispredictE;
  logic [31:0]       o_redirectE;
  logic [PERF_W-1:0] o_branch_cnt;
  logic [PERF_W-1:0] o_miss_cnt;

  modport master (
    output i_pcF, i_validE, i_branchE, i_jumpE, i_takenE, i_pcE, i_targetE,
           i_pcplus4E, i_predtakenE, i_predtargetE,
    input  o_predtakenF, o_predtargetF, o_mispredictE, o_redirectE,
           o_branch_cnt, o_miss_cnt
  );

  modport slave (
    input  i_pcF, i_validE, i_branchE, i_jumpE, i_takenE, i_pcE, i_targetE,
           i_pcplus4E, i_predtakenE, i_predtargetE,
    output o_predtakenF, o_predtargetF, o_mispredictE, o_redirectE,
           o_branch_cnt, o_miss_cnt
  );
endinterface

// File: rtl/bp_btb_param.sv
// bp_btb_param
//   Direct-mapped branch target buffer with per-entry direction counters.
//   Predicts combinationally on the fetch PC, resolves and trains from the
//   execute stage, and keeps saturating branch / mispredict counters.
//   Ports:
//     clk   : pipeline clock
//     reset : asynchronous, active-high; clears table state and counters
//     bus   : bp_btb_param_if.slave (fetch lookup, execute resolve, perf)
//   Parameters: ENTRIES (power of two, 2..256), CNT_W (1..3), PERF_W.
//   Build option: define BP_DIR_COUNTER_EN to use CNT_W-bit saturating
//   direction counters; when undefined the counter is a single bit holding
//   the last outcome.
module bp_btb_param #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int PERF_W  = 32
) (
  input  logic          clk,
  input  logic          reset,
  bp_btb_param_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
`ifdef BP_DIR_COUNTER_EN
  localparam int CW = CNT_W;
`else
  localparam int CW = 1;
`endif
  localparam logic [CW-1:0] CNT_MAX = '1;
  // Weakly taken; in the last-outcome build this is simply "taken".
  localparam logic [CW-1:0] CNT_WT  = CW'(1) << (CW - 1);
  localparam logic [CW-1:0] CNT_WNT = CNT_WT - CW'(1);

  if (ENTRIES < 2 || ENTRIES > 256 || (ENTRIES & (ENTRIES - 1)) != 0 ||
      CNT_W < 1 || CNT_W > 3) begin : g_bad_param
    $error("bp_btb_param: illegal ENTRIES or CNT_W");
  end

  function automatic logic [CW-1:0] cnt_step(input logic [CW-1:0] c, input logic up);
`ifdef BP_DIR_COUNTER_EN
    if (up) return (c == CNT_MAX) ? c : c + CW'(1);
    return (c == '0) ? c : c - CW'(1);
`else
    return up;
`endif
  endfunction

  logic              valid_q [ENTRIES];
  logic              jmp_q   [ENTRIES];
  logic [CW-1:0]     cnt_q   [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [29:0]       tgt_q   [ENTRIES];
  logic              out_en_q;
  logic [PERF_W-1:0] branch_cnt_q;
  logic [PERF_W-1:0] miss_cnt_q;

  // Lookup: table contents are read before any same-cycle update.
  logic [IDX_W-1:0] idxF;
  logic [TAG_W-1:0] tagF;
  logic             hitF;
  logic             predF;

  assign idxF  = bus.i_pcF[IDX_W+1:2];
  assign tagF  = bus.i_pcF[31:IDX_W+2];
  assign hitF  = valid_q[idxF] && (tag_q[idxF] == tagF);
  // out_en_q keeps every output at 0 during reset and the cycle after it.
  assign predF = out_en_q & hitF & (jmp_q[idxF] | cnt_q[idxF][CW-1]);

  assign bus.o_predtakenF  = predF;
  assign bus.o_predtargetF = predF ? {tgt_q[idxF], 2'b00} : 32'h0;

  // Resolve in execute.
  logic cf;
  logic actual;
  assign cf     = out_en_q & bus.i_validE & (bus.i_branchE | bus.i_jumpE);
  assign actual = bus.i_jumpE | bus.i_takenE;

  assign bus.o_mispredictE = cf & ((actual != bus.i_predtakenE) |
                             (actual & bus.i_predtakenE & (bus.i_predtargetE != bus.i_targetE)));
  assign bus.o_redirectE   = !cf ? 32'h0 : (actual ? bus.i_targetE : bus.i_pcplus4E);

  assign bus.o_branch_cnt = branch_cnt_q;
  assign bus.o_miss_cnt   = miss_cnt_q;

  // Training decode.
  logic [IDX_W-1:0] idxE;
  logic [TAG_W-1:0] tagE;
  logic             hitE;
  logic             wr_ctrl;
  logic             wr_tgt;
  logic [CW-1:0]    upd_cnt_d;
  logic             upd_jmp_d;

  assign idxE    = bus.i_pcE[IDX_W+1:2];
  assign tagE    = bus.i_pcE[31:IDX_W+2];
  assign hitE    = valid_q[idxE] && (tag_q[idxE] == tagE);
  // A miss only allocates when taken; a not-taken miss leaves the slot alone.
  assign wr_ctrl = cf & (hitE | actual);
  assign wr_tgt  = cf & actual;

  always_comb begin
    upd_cnt_d = cnt_q[idxE];
    upd_jmp_d = jmp_q[idxE];
    if (hitE) begin
      if (bus.i_jumpE) begin
        upd_jmp_d = 1'b1;
        upd_cnt_d = CNT_MAX;
      end else begin
        upd_cnt_d = cnt_step(cnt_q[idxE], bus.i_takenE);
      end
    end else begin
      upd_jmp_d = bus.i_jumpE;
      upd_cnt_d = bus.i_jumpE ? CNT_MAX : CNT_WT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        jmp_q[i]   <= 1'b0;
        cnt_q[i]   <= CNT_WNT;
      end
      out_en_q     <= 1'b0;
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      out_en_q <= 1'b1;
      if (wr_ctrl) begin
        valid_q[idxE] <= 1'b1;
        jmp_q[idxE]   <= upd_jmp_d;
        cnt_q[idxE]   <= upd_cnt_d;
      end
      if (cf && branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + PERF_W'(1);
      if (bus.o_mispredictE && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + PERF_W'(1);
    end
  end

  // Tag and target are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_tgt) begin
      tag_q[idxE] <= tagE;
      tgt_q[idxE] <= bus.i_targetE[31:2];
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.i_pcF[1:0], bus.i_pcE[1:0], bus.i_targetE[1:0]};
endmodule

// File: tb/tb_bp_btb_param.sv
module tb_bp_btb_param;
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;
`ifdef BP_DIR_COUNTER_EN
  localparam logic        RECOV_T = 1'b0;
  localparam logic [31:0] RECOV_G = 32'h0;
`else
  localparam logic        RECOV_T = 1'b1;
  localparam logic [31:0] RECOV_G = 32'h40;
`endif

  typedef struct {
    logic [31:0] pcf;
    logic v, br, jp, tk;
    logic [31:0] pce, tgt;
    logic ptk;
    logic [31:0] ptgt;
    logic eptk;
    logic [31:0] eptgt;
    logic emis;
    logic [31:0] eredir;
  } step_t;

  typedef struct {
    logic ptk;
    logic [31:0] ptgt;
    logic mis;
    logic [31:0] redir;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  bp_btb_param_if #(.PERF_W(4)) bus ();

  bp_btb_param #(.ENTRIES(16), .CNT_W(2), .PERF_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic set_inputs(input step_t s);
    bus.i_pcF         = s.pcf;
    bus.i_validE      = s.v;
    bus.i_branchE     = s.br;
    bus.i_jumpE       = s.jp;
    bus.i_takenE      = s.tk;
    bus.i_pcE         = s.pce;
    bus.i_targetE     = s.tgt;
    bus.i_pcplus4E    = s.pce + 32'd4;
    bus.i_predtakenE  = s.ptk;
    bus.i_predtargetE = s.ptgt;
  endtask

  task automatic drv(input step_t s);
    @(posedge clk);
    #1;
    set_inputs(s);
    @(negedge clk);
  endtask

  function automatic step_t idle(input logic [31:0] pcf, input logic eptk, input logic [31:0] eptgt);
    step_t s;
    s = '{pcf, N, N, N, N, 32'h0, 32'h0, N, 32'h0, eptk, eptgt, N, 32'h0};
    return s;
  endfunction

  task automatic apply_reset();
    set_inputs(idle(32'h0, N, 32'h0));
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    set_inputs(idle(32'h100, N, 32'h0));
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.o_predtakenF, bus.o_predtargetF, bus.o_branch_cnt, bus.o_miss_cnt} !== 41'h0) begin
      bad++;
      $display("FAIL reset_hold got pt=%0b tg=%h br=%0d ms=%0d want all 0", bus.o_predtakenF,
               bus.o_predtargetF, bus.o_branch_cnt, bus.o_miss_cnt);
    end
    reset = 1'b0;
    // First cycle after reset: a would-be mispredicting branch must stay silent.
    set_inputs('{32'h100, Y, Y, N, Y, 32'h100, 32'h40, N, 32'h0, N, 32'h0, N, 32'h0});
    @(negedge clk);
    total++;
    if ({bus.o_mispredictE, bus.o_redirectE, bus.o_predtakenF} !== 34'h0) begin
      bad++;
      $display("FAIL reset_first_cycle got mis=%0b redir=%h pt=%0b want 0/0/0",
               bus.o_mispredictE, bus.o_redirectE, bus.o_predtakenF);
    end
    sb.push_back('{N, 32'h0, N, 32'h0});
    drv(idle(32'h100, N, 32'h0));
    e = sb.pop_front();
    total++;
    if ({bus.o_predtakenF, bus.o_predtargetF} !== {e.ptk, e.ptgt}) begin
      bad++;
      $display("FAIL reset_lookup got %0b/%h want %0b/%h", bus.o_predtakenF, bus.o_predtargetF, e.ptk, e.ptgt);
    end
    total++;
    if (bus.o_branch_cnt !== 4'd0 || bus.o_miss_cnt !== 4'd0) begin
      bad++;
      $display("FAIL reset_counts got %0d/%0d want 0/0", bus.o_branch_cnt, bus.o_miss_cnt);
    end
  endtask

  task automatic run_steps(input string nm, input step_t st[]);
    exp_t e;
    for (int i = 0; i < st.size(); i++) begin
      sb.push_back('{st[i].eptk, st[i].eptgt, st[i].emis, st[i].eredir});
      drv(st[i]);
      e = sb.pop_front();
      total++;
      if ({bus.o_predtakenF, bus.o_predtargetF} !== {e.ptk, e.ptgt}) begin
        bad++;
        $display("FAIL %s[%0d] pred got %0b/%h want %0b/%h", nm, i, bus.o_predtakenF,
                 bus.o_predtargetF, e.ptk, e.ptgt);
      end
      total++;
      if ({bus.o_mispredictE, bus.o_redirectE} !== {e.mis, e.redir}) begin
        bad++;
        $display("FAIL %s[%0d] resolve got %0b/%h want %0b/%h", nm, i, bus.o_mispredictE,
                 bus.o_redirectE, e.mis, e.redir);
      end
    end
  endtask

  task automatic test_alloc();
    step_t st[];
    st = new[2];
    st[0] = '{32'h100, Y, Y, N, Y, 32'h100, 32'h40, N, 32'h0, N, 32'h0, Y, 32'h40};
    st[1] = idle(32'h100, Y, 32'h40);
    run_steps("alloc", st);
    total++;
    if (bus.o_branch_cnt !== 4'd1 || bus.o_miss_cnt !== 4'd1) begin
      bad++;
      $display("FAIL alloc_counts got %0d/%0d want 1/1", bus.o_branch_cnt, bus.o_miss_cnt);
    end
  endtask

  task automatic test_counter();
    step_t st[];
    st = new[5];
    st[0] = '{32'h100, Y, Y, N, N, 32'h100, 32'h40, Y, 32'h40, Y, 32'h40, Y, 32'h104};
    st[1] = '{32'h100, Y, Y, N, N, 32'h100, 32'h40, N, 32'h0, N, 32'h0, N, 32'h104};
    st[2] = '{32'h100, Y, Y, N, N, 32'h100, 32'h40, N, 32'h0, N, 32'h0, N, 32'h104};
    st[3] = '{32'h100, Y, Y, N, Y, 32'h100, 32'h40, N, 32'h0, N, 32'h0, Y, 32'h40};
    st[4] = idle(32'h100, RECOV_T, RECOV_G);
    run_steps("counter", st);
    total++;
    if (bus.o_branch_cnt !== 4'd5 || bus.o_miss_cnt !== 4'd3) begin
      bad++;
      $display("FAIL counter_counts got %0d/%0d want 5/3", bus.o_branch_cnt, bus.o_miss_cnt);
    end
  endtask

  task automatic test_alias();
    step_t st[];
    apply_reset();
    st = new[4];
    st[0] = '{32'h100, Y, Y, N, Y, 32'h100, 32'h40, N, 32'h0, N, 32'h0, Y, 32'h40};
    st[1] = '{32'h140, Y, Y, N, Y, 32'h140, 32'h80, N, 32'h0, N, 32'h0, Y, 32'h80};
    st[2] = idle(32'h100, N, 32'h0);
    st[3] = idle(32'h140, Y, 32'h80);
    run_steps("alias", st);
  endtask

  task automatic test_jump();
    step_t st[];
    st = new[6];
    st[0] = '{32'h200, Y, N, Y, N, 32'h200, 32'h300, N, 32'h0, N, 32'h0, Y, 32'h300};
    st[1] = idle(32'h200, Y, 32'h300);
    st[2] = '{32'h200, Y, N, Y, N, 32'h200, 32'h304, Y, 32'h300, Y, 32'h300, Y, 32'h304};
    st[3] = idle(32'h200, Y, 32'h304);
    st[4] = '{32'h200, Y, N, Y, N, 32'h200, 32'h304, Y, 32'h304, Y, 32'h304, N, 32'h304};
    st[5] = idle(32'h140, N, 32'h0);
    run_steps("jump", st);
    total++;
    if (bus.o_branch_cnt !== 4'd5 || bus.o_miss_cnt !== 4'd4) begin
      bad++;
      $display("FAIL jump_counts got %0d/%0d want 5/4", bus.o_branch_cnt, bus.o_miss_cnt);
    end
  endtask

  task automatic test_async_reset();
    step_t st[];
    @(posedge clk);
    #1;
    set_inputs('{32'h200, Y, N, Y, N, 32'h200, 32'h300, N, 32'h0, N, 32'h0, N, 32'h0});
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.o_predtakenF, bus.o_predtargetF, bus.o_mispredictE, bus.o_redirectE} !== 66'h0) begin
      bad++;
      $display("FAIL async_reset_outputs got pt=%0b tg=%h mis=%0b redir=%h want 0", bus.o_predtakenF,
               bus.o_predtargetF, bus.o_mispredictE, bus.o_redirectE);
    end
    total++;
    if (bus.o_branch_cnt !== 4'd0 || bus.o_miss_cnt !== 4'd0) begin
      bad++;
      $display("FAIL async_reset_counts got %0d/%0d want 0/0", bus.o_branch_cnt, bus.o_miss_cnt);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    st = new[3];
    st[0] = idle(32'h200, N, 32'h0);
    st[1] = idle(32'h100, N, 32'h0);
    st[2] = idle(32'h140, N, 32'h0);
    run_steps("post_reset", st);
    total++;
    if (bus.o_branch_cnt !== 4'd0 || bus.o_miss_cnt !== 4'd0) begin
      bad++;
      $display("FAIL post_reset_counts got %0d/%0d want 0/0", bus.o_branch_cnt, bus.o_miss_cnt);
    end
  endtask

  task automatic test_perf_sat();
    step_t st[];
    logic ptk;
    apply_reset();
    st = new[21];
    for (int k = 0; k < 20; k++) begin
      ptk = (k % 3 == 0);
      st[k] = '{32'h600, Y, Y, N, N, 32'h500 + 32'(k) * 32'd4, 32'h0, ptk, 32'h0,
                N, 32'h0, ptk, 32'h504 + 32'(k) * 32'd4};
    end
    // Flushed branch: no mispredict, no count even with a taken prediction.
    st[20] = '{32'h600, N, Y, N, N, 32'h580, 32'h0, Y, 32'h0, N, 32'h0, N, 32'h0};
    run_steps("perf", st);
    total++;
    if (bus.o_branch_cnt !== 4'd15) begin
      bad++;
      $display("FAIL perf_branch_sat got %0d want 15", bus.o_branch_cnt);
    end
    total++;
    if (bus.o_miss_cnt !== 4'd7) begin
      bad++;
      $display("FAIL perf_miss got %0d want 7", bus.o_miss_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_counter();
    test_alias();
    test_jump();
    test_async_reset();
    test_perf_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
